ssd_scan_controller: RTL and testbench
======================================

# ssd_scan_controller

Parametrised time-multiplexed seven-segment display scanner and the next generation of the board's SSD driver. It drives NUM_DIGITS common-anode digits from a packed hex input and adds frame-synchronous input capture, per-digit enable, decimal points, leading-zero suppression, anti-ghosting blanking and 16-level PWM brightness. It sits between the switch/register logic and the board's anode/cathode pins; all outputs are registered.

## Interface
- NUM_DIGITS, 8: number of digits scanned; minimum 1.
- REFRESH_CYCLES, 10000: clk cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 64: cycles at the start of each slot with every anode off; minimum 1.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- digits  input  4*NUM_DIGITS  hex nibbles; nibble i is digit i, and digit 0 is the rightmost.
- digit_en  input  NUM_DIGITS  1 = digit i may light.
- dp  input  NUM_DIGITS  1 = decimal point of digit i lit.
- lz_suppress  input  1  1 = blank leading zero digits.
- brightness  input  4  PWM duty level; 15 = full on.
- anode  output  NUM_DIGITS  active-low digit enables.
- cathode  output  8  active-low segments {dp,g,f,e,d,c,b,a}; a is bit 0.
- frame_tick  output  1  one-cycle pulse marking the start of a new frame.

## Operation
- Reset values:
  - Outputs: anode all 1, cathode 8'hFF, frame_tick 0.
  - Internal state: slot_cnt, digit_idx, pwm_cnt and every shadow register are 0.
- slot_cnt (width $clog2(REFRESH_CYCLES)):
  - Counts 0..REFRESH_CYCLES-1.
  - At REFRESH_CYCLES-1 it wraps to 0 and digit_idx increments.
  - digit_idx wraps from NUM_DIGITS-1 to 0.
- pwm_cnt: 4-bit counter, free-running and incremented every cycle, with natural wrap at 16.
- Shadow capture:
  - In every cycle with digit_idx==0 and slot_cnt==0, shadow registers load digits, digit_en, dp, lz_suppress and brightness.
  - This includes the first edge after reset release.
  - Display content is taken only from the shadow, so there is no tearing inside a frame.
- Leading-zero suppression, evaluated from the shadow:
  - When lz_suppress=1, digit i is suppressed if its nibble and every nibble above it are 0.
  - Digit 0 is never suppressed.
  - Suppressed digits keep their anode off even when their dp bit is set.
- Digit i is shown when: digit_en[i]=1 and i is not suppressed.
- Segment decode:
  - Standard hex 0-F, active-low.
  - Values: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (bit 7 = 1).
  - dp[i]=1 clears bit 7.
- Anode for the current digit_idx is driven low when all of the following hold: the digit is shown, slot_cnt >= BLANK_CYCLES, and pwm_cnt <= shadow brightness. All other anodes stay high.
- Cathode:
  - Driven with the decode of the current digit for the whole slot, including the blank window, so segments settle before the anode turns on.
  - 8'hFF for a digit that is not shown.

## Timing
- Outputs are registered. anode and cathode reflect the slot_cnt, digit_idx, pwm_cnt and shadow values of the previous cycle, giving 1 cycle of latency.
- frame_tick is high in the cycle after each shadow load, coincident with the first decoded output of the new frame.
  - Period: NUM_DIGITS*REFRESH_CYCLES.
- Input changes appear on the outputs 1 cycle after the next frame start.
  - Worst case: NUM_DIGITS*REFRESH_CYCLES+1 cycles.
- Duty per slot: anode is low for (brightness+1)/16 of cycles in the non-blank window, rounded by pwm_cnt phase.
  - brightness=15 keeps the anode low through the whole non-blank window.
- At no time is more than one anode low.
  - Across a slot boundary, all anodes are high for at least BLANK_CYCLES cycles.
- Reset asserted mid-slot: outputs go to reset values immediately, with no clock edge needed.
- After reset release: the first rising edge loads the shadow and starts digit 0 slot 0.

## Structure
- Package ssd_pkg holds:
  - Segment-pattern localparams (SEG_0..SEG_F, SEG_BLANK = 8'hFF).
  - Function seg_decode(nibble, dp).
- Sub-module ssd_hex_decode: combinational nibble+dp to cathode byte, built on the package function.
- The top-level module holds the counters, shadow registers, suppression logic and output registers.

## Test plan
Bench configuration: NUM_DIGITS=4, REFRESH_CYCLES=20, BLANK_CYCLES=2.
- Reset, then digits=16'h1234, digit_en=4'hF, brightness=15.
  - During reset: anode=4'hF, cathode=8'hFF.
  - Digit 0 slot: cathode=8'h99, anode=4'b1110 for exactly slot cycles 2..19.
- Change digits to 16'h5678 mid-frame.
  - Output is unchanged until frame_tick.
  - frame_tick pulses every 80 cycles.
  - The new frame shows digit 0 = 8'h80.
- digits=16'h0050, lz_suppress=1.
  - Digits 3 and 2: anode never low.
  - Digit 1 shows 8'h92; digit 0 shows 8'hC0.
- digits=16'h0050, lz_suppress=1, dp=4'b0010: digit 1 cathode=8'h12.
- brightness=3: within each non-blank window, anode is low only when pwm_cnt<=3 (4 of every 16 cycles). digit_en=4'b1011: digit 2 is never lit.
- Assert reset asynchronously mid-slot: anode and cathode go to all-ones before the next clk edge. After release, scanning restarts at digit 0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: active-low segment
// patterns {dp,g,f,e,d,c,b,a} and the hex decode helper.
package ssd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // dp is active-low on bit 7, so a lit point clears it
  function automatic logic [7:0] seg_decode(input logic [3:0] nibble, input logic dp);
    logic [7:0] s;
    case (nibble)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    seg_decode = dp ? (s & 8'h7F) : s;
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble + decimal point to active-low cathode byte.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg_decode(nibble_i, dp_i);

endmodule

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed common-anode scanner: frame-synchronous shadow capture,
// leading-zero suppression, anti-ghost blanking and 16-level PWM.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CYCLES = 10000,
  parameter int BLANK_CYCLES   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_tick
);

  localparam int SW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_BLANK = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

  logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]           digit_idx_q, digit_idx_d;
  logic [3:0]              pwm_cnt_q;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    sh_lz_q, sh_lz_d;
  logic [3:0]              sh_bright_q, sh_bright_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;
  logic                    tick_q;
  logic                    load;
  logic                    shown;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   supp;
  logic [7:0]              seg;

  assign load = (digit_idx_q == '0) && (slot_cnt_q == '0);

  always_comb begin
    slot_cnt_d  = slot_cnt_q + SW'(1);
    digit_idx_d = digit_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == DIG_LAST) ? '0 : digit_idx_q + DW'(1);
    end
  end

  // Decode uses the shadow's next value so the first slot of a frame
  // already shows the freshly captured inputs, aligned with frame_tick.
  assign sh_digits_d = load ? digits      : sh_digits_q;
  assign sh_en_d     = load ? digit_en    : sh_en_q;
  assign sh_dp_d     = load ? dp          : sh_dp_q;
  assign sh_lz_d     = load ? lz_suppress : sh_lz_q;
  assign sh_bright_d = load ? brightness  : sh_bright_q;

  always_comb begin
    zero_above = 1'b1;
    supp       = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (sh_digits_d[4*i +: 4] == 4'h0);
      supp[i]    = sh_lz_d & zero_above;
    end
  end

  ssd_hex_decode u_dec (
    .nibble_i (sh_digits_d[4*digit_idx_q +: 4]),
    .dp_i     (sh_dp_d[digit_idx_q]),
    .seg_o    (seg)
  );

  assign shown = sh_en_d[digit_idx_q] & ~supp[digit_idx_q];

  always_comb begin
    anode_d   = '1;
    cathode_d = shown ? seg : SEG_BLANK;
    if (shown && (slot_cnt_q >= SLOT_BLANK) && (pwm_cnt_q <= sh_bright_d))
      anode_d[digit_idx_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      pwm_cnt_q   <= '0;
      sh_digits_q <= '0;
      sh_en_q     <= '0;
      sh_dp_q     <= '0;
      sh_lz_q     <= 1'b0;
      sh_bright_q <= '0;
      anode_q     <= '1;
      cathode_q   <= SEG_BLANK;
      tick_q      <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      pwm_cnt_q   <= pwm_cnt_q + 4'd1;
      sh_digits_q <= sh_digits_d;
      sh_en_q     <= sh_en_d;
      sh_dp_q     <= sh_dp_d;
      sh_lz_q     <= sh_lz_d;
      sh_bright_q <= sh_bright_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
      tick_q      <= load;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed vector bench for ssd_scan_controller (4 digits, 20-cycle slots, 2-cycle blank).
module tb_ssd_scan_controller;

  localparam int ND  = 4;
  localparam int RC  = 20;
  localparam int BC  = 2;
  localparam int FRM = ND * RC;
  localparam int NV  = 7;

  typedef struct {
    string            name;
    logic [15:0]      digits;
    logic [3:0]       en;
    logic [3:0]       dp;
    logic             lz;
    logic [3:0]       bright;
    logic [3:0][7:0]  cath;   // expected cathode per digit when shown
    logic [3:0]       shown;  // expected lit digits
  } vec_t;

  logic        clk, rst;
  logic [15:0] digits;
  logic [3:0]  digit_en, dp, brightness;
  logic        lz_suppress;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int ncyc;
  vec_t tbl [NV];

  ssd_scan_controller #(.NUM_DIGITS(ND), .REFRESH_CYCLES(RC), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .reset       (rst),
    .digits      (digits),
    .digit_en    (digit_en),
    .dp          (dp),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .anode       (anode),
    .cathode     (cathode),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rising edges since reset release; edge n presents the state of cycle n-1
  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  task automatic apply(input vec_t v);
    digits      = v.digits;
    digit_en    = v.en;
    dp          = v.dp;
    lz_suppress = v.lz;
    brightness  = v.bright;
  endtask

  task automatic check_cycle(input vec_t v);
    int k, slot, idx, pwm;
    logic [3:0] ea;
    logic [7:0] ec;
    logic       et;
    k    = ncyc - 1;
    slot = k % RC;
    idx  = (k / RC) % ND;
    pwm  = k % 16;
    ea   = 4'hF;
    ec   = v.shown[idx] ? v.cath[idx] : 8'hFF;
    if (v.shown[idx] && slot >= BC && pwm <= int'(v.bright)) ea[idx] = 1'b0;
    et   = (k % FRM == 0);
    checks++;
    if (anode !== ea || cathode !== ec || frame_tick !== et) begin
      failures++;
      $display("FAIL %s k=%0d digit=%0d slot=%0d: anode=%b want %b, cathode=%h want %h, tick=%b want %b",
               v.name, k, idx, slot, anode, ea, cathode, ec, frame_tick, et);
    end
  endtask

  task automatic check_reset(input string nm);
    checks++;
    if (anode !== 4'hF || cathode !== 8'hFF || frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL %s: anode=%b want 1111, cathode=%h want ff, tick=%b want 0",
               nm, anode, cathode, frame_tick);
    end
  endtask

  // wait for the next frame_tick, checking the old frame content meanwhile
  task automatic wait_tick(input vec_t old, input bit chk_old, input string nm);
    bit got;
    got = 0;
    for (int c = 0; c < 2 * FRM && !got; c++) begin
      @(negedge clk);
      if (frame_tick) got = 1;
      else if (chk_old) check_cycle(old);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s: frame_tick not seen within %0d cycles", nm, 2 * FRM);
    end
  endtask

  initial begin
    tbl[0] = '{"hex1234",    16'h1234, 4'hF,    4'h0,    1'b0, 4'd15,
               {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b1111};
    tbl[1] = '{"hex5678",    16'h5678, 4'hF,    4'h0,    1'b0, 4'd15,
               {8'h92, 8'h82, 8'hF8, 8'h80}, 4'b1111};
    tbl[2] = '{"lz0050",     16'h0050, 4'hF,    4'h0,    1'b1, 4'd15,
               {8'hFF, 8'hFF, 8'h92, 8'hC0}, 4'b0011};
    tbl[3] = '{"lz0050_dp1", 16'h0050, 4'hF,    4'b0010, 1'b1, 4'd15,
               {8'hFF, 8'hFF, 8'h12, 8'hC0}, 4'b0011};
    tbl[4] = '{"pwm3_en1011", 16'h9ABC, 4'b1011, 4'h0,   1'b0, 4'd3,
               {8'h90, 8'hFF, 8'h83, 8'hC6}, 4'b1011};
    tbl[5] = '{"lz00F0_dp2", 16'h00F0, 4'hF,    4'b0100, 1'b1, 4'd15,
               {8'hFF, 8'hFF, 8'h8E, 8'hC0}, 4'b0011};
    tbl[6] = '{"zero_dp0",   16'h0000, 4'hF,    4'b0001, 1'b1, 4'd15,
               {8'hFF, 8'hFF, 8'hFF, 8'h40}, 4'b0001};

    rst = 1'b1;
    apply(tbl[0]);
    #2 check_reset("reset_async_initial");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_reset("reset_hold");
    end
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i == 0) begin
        wait_tick(tbl[0], 1'b0, "first_tick");
      end else begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          check_cycle(tbl[i-1]);
        end
        apply(tbl[i]);
        wait_tick(tbl[i-1], 1'b1, tbl[i].name);
      end
      check_cycle(tbl[i]);
      for (int c = 1; c < FRM; c++) begin
        @(negedge clk);
        check_cycle(tbl[i]);
      end
    end

    // asynchronous reset while digit 0 is lit, then restart from digit 0
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_cycle(tbl[NV-1]);
    end
    #2 rst = 1'b1;
    #1 check_reset("reset_mid_slot");
    @(negedge clk);
    check_reset("reset_mid_hold");
    rst = 1'b0;
    wait_tick(tbl[NV-1], 1'b0, "restart_tick");
    check_cycle(tbl[NV-1]);
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      check_cycle(tbl[NV-1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
